ps2_rx: RTL and testbench

- PS/2 device-to-host receiver between the keyboard pins (GPIO[28]/GPIO[29]) and the terminal's keyboard/scancode logic.
- Synchronizes and deglitches the PS/2 clock and data lines, then deframes 11-bit frames (start, 8 data bits LSB first, odd parity, stop).
- Checks each frame and buffers good bytes in a small FIFO.
- Presents bytes on a valid/ready interface.
- Receive only; the line is never driven.

---
 rtl/ps2_rx.sv | 176 +++++++++++++++++
 tb/tb_ps2_rx.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: conditions the raw clock and data pins, deframes
// 11-bit frames, flags framing and parity faults, and queues good bytes.

module ps2_rx_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level
);
  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Both stages and the level reset high so a line held low at reset release
  // still needs a full FILTER_LEN run before it can register as a fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
    end else begin
      sync <= {sync[0], pin};
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

module ps2_rx #(
  parameter int CLK_HZ     = 50000000,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_US = 200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overflow,
  output logic       busy
);
  localparam int LIMIT = CLK_HZ / 1000000 * TIMEOUT_US;
  localparam int TW    = $clog2(LIMIT + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // line index 0 = clock, 1 = data
  logic [1:0] pin_raw, pin_flt;
  assign pin_raw = {ps2_data, ps2_clk};

  for (genvar g = 0; g < 2; g++) begin : g_line
    ps2_rx_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
      .clk  (clk),
      .reset(reset),
      .pin  (pin_raw[g]),
      .level(pin_flt[g])
    );
  end

  logic clk_prev, fall, dat;
  assign fall = clk_prev & ~pin_flt[0];
  assign dat  = pin_flt[1];

  state_t        state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          par_bit, par_bit_n;
  logic [TW-1:0] tcnt;
  logic          push_req, perr, ferr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      tcnt     <= '0;
      clk_prev <= 1'b1;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      shreg    <= shreg_n;
      par_bit  <= par_bit_n;
      clk_prev <= pin_flt[0];
      tcnt     <= (fall || state == IDLE) ? '0 : tcnt + TW'(1);
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    par_bit_n = par_bit;
    push_req  = 1'b0;
    perr      = 1'b0;
    ferr      = 1'b0;
    case (state)
      IDLE: if (fall) begin
        if (!dat) begin
          state_n   = DATA;
          bit_cnt_n = '0;
        end else begin
          ferr = 1'b1;
        end
      end
      DATA: if (fall) begin
        shreg_n   = {dat, shreg[7:1]};
        bit_cnt_n = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) state_n = PARITY;
      end
      PARITY: if (fall) begin
        par_bit_n = dat;
        state_n   = STOP;
      end
      STOP: if (fall) begin
        state_n = IDLE;
        if (!dat)                       ferr     = 1'b1;
        else if (^{shreg, par_bit} == 1'b0) perr = 1'b1;
        else                            push_req = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    // A stalled frame is abandoned; the counter is one short of LIMIT here so
    // the pulse lands exactly LIMIT cycles after the last fall.
    if (state != IDLE && !fall && tcnt == TW'(LIMIT - 1)) begin
      state_n   = IDLE;
      bit_cnt_n = '0;
      ferr      = 1'b1;
    end
  end

  // show-ahead byte FIFO; extra pointer bit separates full from empty
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, pop, do_push;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign valid   = (wr_ptr != rd_ptr);
  assign pop     = valid & ready;
  assign do_push = push_req & (~full | pop);
  assign data    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= shreg;
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  assign parity_err = perr & ~reset;
  assign frame_err  = ferr & ~reset;
  assign overflow   = push_req & full & ~pop & ~reset;
  assign busy       = (state != IDLE);
endmodule

// File: tb/tb_ps2_rx.sv
// Bench for ps2_rx: bit-level PS/2 frames driven on the pins, good bytes checked
// through a scoreboard queue, error pulses counted per scenario.

module tb_ps2_rx;
  localparam int FL    = 8;
  localparam int LIMIT = 10000;
  localparam int LAT   = FL + 2;   // pin fall -> internal fall cycle, in negedges
  localparam int H     = 40;       // fast half-bit, in clocks

  logic       clk = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1, ready = 1'b0;
  logic [7:0] data;
  logic       valid, parity_err, frame_err, overflow, busy;

  int         nchecks = 0, nerrors = 0;
  int         n_perr = 0, n_ferr = 0, n_ovf = 0;
  bit         busy_seen = 0;
  logic [7:0] q[$];
  logic [7:0] exp_b;

  always #10 clk = ~clk;

  ps2_rx #(.CLK_HZ(50000000), .FILTER_LEN(FL), .TIMEOUT_US(200), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .data(data), .valid(valid), .ready(ready),
    .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow), .busy(busy)
  );

  // pulse counters and scoreboard pop, sampled mid-cycle
  always @(negedge clk) begin
    #1;
    if (!reset) begin
      if (parity_err) n_perr++;
      if (frame_err)  n_ferr++;
      if (overflow)   n_ovf++;
      if (busy)       busy_seen = 1;
      if (valid && ready) begin
        nchecks++;
        if (q.size() == 0) begin
          nerrors++;
          $display("FAIL scoreboard: unexpected byte %h", data);
        end else begin
          exp_b = q.pop_front();
          if (data !== exp_b) begin
            nerrors++;
            $display("FAIL scoreboard: data=%h expected %h", data, exp_b);
          end
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic opar(input logic [7:0] b);
    return ~(^b);
  endfunction

  task automatic ps2_bit(input logic b, input int half, input bit pop);
    @(negedge clk); ps2_data = b;
    repeat (half) @(negedge clk);
    ps2_clk = 1'b0;
    for (int i = 1; i <= half; i++) begin
      @(negedge clk);
      if (pop && i == LAT) ready = 1'b1;
      else if (pop && i == LAT + 1) ready = 1'b0;
    end
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp,
                            input int half, input bit pop_at_stop);
    ps2_bit(1'b0, half, 0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], half, 0);
    ps2_bit(par, half, 0);
    ps2_bit(stp, half, pop_at_stop);
    @(negedge clk); ps2_data = 1'b1;
    repeat (half) @(negedge clk);
  endtask

  task automatic clear_counts();
    n_perr = 0; n_ferr = 0; n_ovf = 0; busy_seen = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    nchecks++;
    if (data !== 8'h00 || valid !== 1'b0 || busy !== 1'b0) begin
      nerrors++;
      $display("FAIL reset_outputs: data=%h valid=%b busy=%b expected 00 0 0", data, valid, busy);
    end
    nchecks++;
    if ({parity_err, frame_err, overflow} !== 3'b000) begin
      nerrors++;
      $display("FAIL reset_pulses: got %b expected 000", {parity_err, frame_err, overflow});
    end
    @(negedge clk); reset = 1'b0;
    clear_counts();
    repeat (30) @(negedge clk);
    nchecks++;
    if (busy_seen || n_ferr != 0) begin
      nerrors++;
      $display("FAIL reset_idle: busy_seen=%b frame_err=%0d expected 0 0", busy_seen, n_ferr);
    end
  endtask

  task automatic test_good_frame();
    logic [7:0] b;
    b = 8'h1C;
    clear_counts();
    ready = 1'b0;
    q.push_back(b);
    ps2_bit(1'b0, 2000, 0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], 2000, 0);
    ps2_bit(1'b0, 2000, 0);
    @(negedge clk); ps2_data = 1'b1;
    repeat (2000) @(negedge clk);
    ps2_clk = 1'b0;
    for (int i = 1; i <= 2000; i++) begin
      @(negedge clk); #1;
      if (i == LAT) begin
        nchecks++;
        if (valid !== 1'b0) begin
          nerrors++;
          $display("FAIL good_latency_early: valid=%b expected 0", valid);
        end
      end
      if (i == LAT + 1) begin
        nchecks++;
        if (valid !== 1'b1 || data !== 8'h1C || busy !== 1'b0) begin
          nerrors++;
          $display("FAIL good_frame: valid=%b data=%h busy=%b expected 1 1c 0", valid, data, busy);
        end
      end
    end
    ps2_clk = 1'b1;
    nchecks++;
    if (n_perr != 0 || n_ferr != 0 || n_ovf != 0) begin
      nerrors++;
      $display("FAIL good_pulses: perr=%0d ferr=%0d ovf=%0d expected 0 0 0", n_perr, n_ferr, n_ovf);
    end
    ready = 1'b1;
    for (int i = 0; i < 100 && (q.size() != 0 || valid); i++) @(negedge clk);
    ready = 1'b0;
    nchecks++;
    if (q.size() != 0 || valid !== 1'b0) begin
      nerrors++;
      $display("FAIL good_drain: pending=%0d valid=%b expected 0 0", q.size(), valid);
    end
  endtask

  task automatic test_parity();
    clear_counts();
    send_frame(8'hF0, 1'b0, 1'b1, H, 0);
    nchecks++;
    if (n_perr != 1 || n_ferr != 0 || valid !== 1'b0) begin
      nerrors++;
      $display("FAIL bad_parity: perr=%0d ferr=%0d valid=%b expected 1 0 0", n_perr, n_ferr, valid);
    end
    q.push_back(8'hF0);
    send_frame(8'hF0, 1'b1, 1'b1, H, 0);
    nchecks++;
    if (n_perr != 1 || valid !== 1'b1) begin
      nerrors++;
      $display("FAIL parity_recover: perr=%0d valid=%b expected 1 1", n_perr, valid);
    end
    ready = 1'b1;
    for (int i = 0; i < 100 && (q.size() != 0 || valid); i++) @(negedge clk);
    ready = 1'b0;
    nchecks++;
    if (q.size() != 0) begin
      nerrors++;
      $display("FAIL parity_drain: pending=%0d expected 0", q.size());
    end
  endtask

  task automatic test_stop();
    clear_counts();
    send_frame(8'h55, 1'b0, 1'b0, H, 0);
    nchecks++;
    if (n_ferr != 1 || n_perr != 0 || valid !== 1'b0) begin
      nerrors++;
      $display("FAIL bad_stop: ferr=%0d perr=%0d valid=%b expected 1 0 0", n_ferr, n_perr, valid);
    end
    clear_counts();
    ps2_bit(1'b1, H, 0);
    ps2_bit(1'b1, H, 0);
    repeat (H) @(negedge clk);
    nchecks++;
    if (n_ferr != 2 || busy_seen) begin
      nerrors++;
      $display("FAIL bad_start: ferr=%0d busy_seen=%b expected 2 0", n_ferr, busy_seen);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] b;
    clear_counts();
    ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      b = 8'(i);
      q.push_back(b);
      send_frame(b, opar(b), 1'b1, H, 0);
    end
    nchecks++;
    if (n_ovf != 0) begin
      nerrors++;
      $display("FAIL ovf_early: overflow=%0d expected 0", n_ovf);
    end
    b = 8'h05;
    send_frame(b, opar(b), 1'b1, H, 0);
    nchecks++;
    if (n_ovf != 1 || valid !== 1'b1) begin
      nerrors++;
      $display("FAIL ovf_fifth: overflow=%0d valid=%b expected 1 1", n_ovf, valid);
    end
    ready = 1'b1;
    for (int i = 0; i < 100 && (q.size() != 0 || valid); i++) @(negedge clk);
    ready = 1'b0;
    nchecks++;
    if (q.size() != 0 || valid !== 1'b0) begin
      nerrors++;
      $display("FAIL ovf_drain: pending=%0d valid=%b expected 0 0", q.size(), valid);
    end
    for (int i = 6; i <= 9; i++) begin
      b = 8'(i);
      q.push_back(b);
      send_frame(b, opar(b), 1'b1, H, 0);
    end
    clear_counts();
    b = 8'h0A;
    q.push_back(b);
    send_frame(b, opar(b), 1'b1, H, 1);
    nchecks++;
    if (n_ovf != 0 || q.size() != 4) begin
      nerrors++;
      $display("FAIL full_push_pop: overflow=%0d pending=%0d expected 0 4", n_ovf, q.size());
    end
    ready = 1'b1;
    for (int i = 0; i < 100 && (q.size() != 0 || valid); i++) @(negedge clk);
    ready = 1'b0;
    nchecks++;
    if (q.size() != 0 || valid !== 1'b0) begin
      nerrors++;
      $display("FAIL full_drain: pending=%0d valid=%b expected 0 0", q.size(), valid);
    end
  endtask

  task automatic test_timeout();
    int first;
    first = -1;
    clear_counts();
    ps2_bit(1'b0, H, 0);
    ps2_bit(1'b0, H, 0);
    ps2_bit(1'b1, H, 0);
    ps2_bit(1'b0, H, 0);
    @(negedge clk); ps2_data = 1'b1;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    for (int i = 1; i <= LAT + LIMIT + 200; i++) begin
      @(negedge clk);
      if (i == H) ps2_clk = 1'b1;
      #1;
      if (frame_err && first < 0) first = i;
    end
    nchecks++;
    if (first != LAT + LIMIT) begin
      nerrors++;
      $display("FAIL timeout_cycle: frame_err at %0d expected %0d", first, LAT + LIMIT);
    end
    nchecks++;
    if (n_ferr != 1 || busy !== 1'b0 || valid !== 1'b0) begin
      nerrors++;
      $display("FAIL timeout_state: ferr=%0d busy=%b valid=%b expected 1 0 0", n_ferr, busy, valid);
    end
    clear_counts();
    q.push_back(8'h5A);
    send_frame(8'h5A, opar(8'h5A), 1'b1, H, 0);
    ready = 1'b1;
    for (int i = 0; i < 100 && (q.size() != 0 || valid); i++) @(negedge clk);
    ready = 1'b0;
    nchecks++;
    if (q.size() != 0 || n_ferr != 0) begin
      nerrors++;
      $display("FAIL timeout_recover: pending=%0d ferr=%0d expected 0 0", q.size(), n_ferr);
    end
  endtask

  task automatic test_glitch_reset();
    clear_counts();
    @(negedge clk); ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (30) @(negedge clk);
    nchecks++;
    if (busy_seen || n_ferr != 0) begin
      nerrors++;
      $display("FAIL glitch: busy_seen=%b ferr=%0d expected 0 0", busy_seen, n_ferr);
    end
    ready = 1'b0;
    send_frame(8'h33, opar(8'h33), 1'b1, H, 0);
    nchecks++;
    if (valid !== 1'b1) begin
      nerrors++;
      $display("FAIL prereset_fill: valid=%b expected 1", valid);
    end
    clear_counts();
    ps2_bit(1'b0, H, 0);
    for (int i = 0; i < 5; i++) ps2_bit(i[0], H, 0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    #1;
    nchecks++;
    if (busy !== 1'b0 || valid !== 1'b0 || {parity_err, frame_err, overflow} !== 3'b000) begin
      nerrors++;
      $display("FAIL midframe_reset: busy=%b valid=%b pulses=%b expected 0 0 000",
               busy, valid, {parity_err, frame_err, overflow});
    end
    q.push_back(8'hA3);
    send_frame(8'hA3, opar(8'hA3), 1'b1, H, 0);
    ready = 1'b1;
    for (int i = 0; i < 100 && (q.size() != 0 || valid); i++) @(negedge clk);
    ready = 1'b0;
    nchecks++;
    if (q.size() != 0 || n_ferr != 0 || n_perr != 0 || n_ovf != 0) begin
      nerrors++;
      $display("FAIL post_reset_frame: pending=%0d ferr=%0d perr=%0d ovf=%0d expected 0 0 0 0",
               q.size(), n_ferr, n_perr, n_ovf);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity();
    test_stop();
    test_overflow();
    test_timeout();
    test_glitch_reset();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end
endmodule
